// File: rtl/pong_pkg.sv
// Shared geometry defaults, velocity type and game state encoding for the pong datapath.
package pong_pkg;

  localparam int DEF_SCREEN_W   = 640;
  localparam int DEF_SCREEN_H   = 480;
  localparam int DEF_PADDLE_W   = 5;
  localparam int DEF_PADDLE_H   = 50;
  localparam int DEF_BALL_SIZE  = 4;
  localparam int DEF_P1_X       = 0;
  localparam int DEF_P2_X       = 635;
  localparam int DEF_PADDLE_STEP = 4;
  localparam int DEF_BALL_STEP  = 2;
  localparam int DEF_SCORE_HOLD = 60;
  localparam int DEF_WIN_SCORE  = 9;

  // 11-bit signed keeps "position + velocity" from wrapping below zero
  localparam int VEL_W = 11;
  typedef logic signed [VEL_W-1:0] vel_t;

  typedef enum logic [1:0] {
    ST_SERVE  = 2'd0,
    ST_PLAY   = 2'd1,
    ST_SCORED = 2'd2,
    ST_OVER   = 2'd3
  } pong_state_e;

  function automatic vel_t to_vel(input logic [9:0] pos);
    return vel_t'({1'b0, pos});
  endfunction

endpackage

// File: rtl/paddle_ctrl.sv
// One paddle: steps up/down on an enabled frame and clamps to the visible range.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int PADDLE_H    = DEF_PADDLE_H,
  parameter int PADDLE_STEP = DEF_PADDLE_STEP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       move_en,
  input  logic       up,
  input  logic       dn,
  output logic [9:0] y
);

  localparam int Y_MAX  = SCREEN_H - PADDLE_H;
  localparam int Y_INIT = Y_MAX / 2;

  logic [9:0] y_q, y_d;
  vel_t       y_next;

  always_comb begin
    y_d    = y_q;
    y_next = to_vel(y_q);
    // Both buttons held cancel each other out
    if (move_en && (up ^ dn)) begin
      y_next = up ? (y_next - vel_t'(PADDLE_STEP)) : (y_next + vel_t'(PADDLE_STEP));
      if (y_next < 0)
        y_d = '0;
      else if (y_next > vel_t'(Y_MAX))
        y_d = 10'(Y_MAX);
      else
        y_d = y_next[9:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) y_q <= 10'(Y_INIT);
    else        y_q <= y_d;
  end

  assign y = y_q;

endmodule

// File: rtl/pong_physics.sv
// Frame-stepped pong game: ball motion, wall/paddle reflection, scoring and serve flow.
module pong_physics
  import pong_pkg::*;
#(
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int PADDLE_W    = DEF_PADDLE_W,
  parameter int PADDLE_H    = DEF_PADDLE_H,
  parameter int BALL_SIZE   = DEF_BALL_SIZE,
  parameter int P1_X        = DEF_P1_X,
  parameter int P2_X        = DEF_P2_X,
  parameter int PADDLE_STEP = DEF_PADDLE_STEP,
  parameter int BALL_STEP   = DEF_BALL_STEP,
  parameter int SCORE_HOLD  = DEF_SCORE_HOLD,
  parameter int WIN_SCORE   = DEF_WIN_SCORE
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        p1_up,
  input  logic        p1_dn,
  input  logic        p2_up,
  input  logic        p2_dn,
  input  logic        serve,
  output logic [9:0]  ball_x,
  output logic [9:0]  ball_y,
  output logic [9:0]  p1_y,
  output logic [9:0]  p2_y,
  output logic [3:0]  score_p1,
  output logic [3:0]  score_p2,
  output logic        point_pulse,
  output logic        game_over,
  output pong_state_e state_dbg
);

  localparam int BALL_X0 = (SCREEN_W - BALL_SIZE) / 2;
  localparam int BALL_Y0 = (SCREEN_H - BALL_SIZE) / 2;
  localparam int BY_MAX  = SCREEN_H - BALL_SIZE;
  localparam int LEFT_X  = P1_X + PADDLE_W;
  localparam int RIGHT_X = P2_X - BALL_SIZE;
  localparam int HOLD_W  = $clog2(SCORE_HOLD + 1);

  pong_state_e       state_q, state_d;
  logic [9:0]        bx_q, bx_d, by_q, by_d;
  vel_t              vx_q, vx_d, vy_q, vy_d;
  logic [3:0]        s1_q, s1_d, s2_q, s2_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              loser_p1_q, loser_p1_d;
  logic              pp_q, pp_d, go_q, go_d;

  vel_t nx, ny;
  logic hit_p1, hit_p2, miss_l, miss_r, paddle_en;

  assign paddle_en = frame_tick && (state_q == ST_SERVE || state_q == ST_PLAY);

  paddle_ctrl #(.SCREEN_H(SCREEN_H), .PADDLE_H(PADDLE_H), .PADDLE_STEP(PADDLE_STEP)) u_paddle_p1 (
    .clk(pixel_clk), .rst_n(rst_n), .move_en(paddle_en), .up(p1_up), .dn(p1_dn), .y(p1_y)
  );

  paddle_ctrl #(.SCREEN_H(SCREEN_H), .PADDLE_H(PADDLE_H), .PADDLE_STEP(PADDLE_STEP)) u_paddle_p2 (
    .clk(pixel_clk), .rst_n(rst_n), .move_en(paddle_en), .up(p2_up), .dn(p2_dn), .y(p2_y)
  );

  always_comb begin
    state_d    = state_q;
    bx_d       = bx_q;
    by_d       = by_q;
    vx_d       = vx_q;
    vy_d       = vy_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    hold_d     = hold_q;
    loser_p1_d = loser_p1_q;
    pp_d       = 1'b0;
    miss_l     = 1'b0;
    miss_r     = 1'b0;
    nx         = to_vel(bx_q) + vx_q;
    ny         = to_vel(by_q) + vy_q;
    // Overlap is judged against the paddle position in force before this frame
    hit_p1 = (({1'b0, by_q} + 11'(BALL_SIZE)) > {1'b0, p1_y}) &&
             ({1'b0, by_q} < ({1'b0, p1_y} + 11'(PADDLE_H)));
    hit_p2 = (({1'b0, by_q} + 11'(BALL_SIZE)) > {1'b0, p2_y}) &&
             ({1'b0, by_q} < ({1'b0, p2_y} + 11'(PADDLE_H)));

    case (state_q)
      ST_SERVE: begin
        bx_d = 10'(BALL_X0);
        by_d = 10'(BALL_Y0);
        if (serve) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (frame_tick) begin
          if (ny < 0) begin
            by_d = '0;
            vy_d = -vy_q;
          end else if (ny > vel_t'(BY_MAX)) begin
            by_d = 10'(BY_MAX);
            vy_d = -vy_q;
          end else begin
            by_d = ny[9:0];
          end
          bx_d = nx[9:0];
          if (vx_q < 0 && nx <= vel_t'(LEFT_X)) begin
            if (hit_p1) begin
              bx_d = 10'(LEFT_X);
              vx_d = -vx_q;
            end else begin
              miss_l = 1'b1;
            end
          end else if (vx_q > 0 && (nx + vel_t'(BALL_SIZE)) >= vel_t'(P2_X)) begin
            if (hit_p2) begin
              bx_d = 10'(RIGHT_X);
              vx_d = -vx_q;
            end else begin
              miss_r = 1'b1;
            end
          end
          // On a miss the ball stays where it was for the whole hold period
          if (miss_l || miss_r) begin
            bx_d       = bx_q;
            by_d       = by_q;
            vy_d       = vy_q;
            pp_d       = 1'b1;
            state_d    = ST_SCORED;
            hold_d     = '0;
            loser_p1_d = miss_l;
            if (miss_l && s2_q != 4'(WIN_SCORE)) s2_d = s2_q + 4'd1;
            if (miss_r && s1_q != 4'(WIN_SCORE)) s1_d = s1_q + 4'd1;
          end
        end
      end
      ST_SCORED: begin
        if (frame_tick) begin
          if (hold_q == HOLD_W'(SCORE_HOLD - 1)) begin
            hold_d = '0;
            if (s1_q == 4'(WIN_SCORE) || s2_q == 4'(WIN_SCORE)) begin
              state_d = ST_OVER;
            end else begin
              state_d = ST_SERVE;
              bx_d    = 10'(BALL_X0);
              by_d    = 10'(BALL_Y0);
              vx_d    = loser_p1_q ? -vel_t'(BALL_STEP) : vel_t'(BALL_STEP);
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      ST_OVER: begin
        if (serve) begin
          state_d = ST_SERVE;
          s1_d    = '0;
          s2_d    = '0;
          bx_d    = 10'(BALL_X0);
          by_d    = 10'(BALL_Y0);
          vx_d    = vel_t'(BALL_STEP);
          vy_d    = vel_t'(BALL_STEP);
        end
      end
      default: state_d = ST_SERVE;
    endcase
    go_d = (state_d == ST_OVER);
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      state_q    <= ST_SERVE;
      bx_q       <= 10'(BALL_X0);
      by_q       <= 10'(BALL_Y0);
      vx_q       <= vel_t'(BALL_STEP);
      vy_q       <= vel_t'(BALL_STEP);
      s1_q       <= '0;
      s2_q       <= '0;
      hold_q     <= '0;
      loser_p1_q <= 1'b0;
      pp_q       <= 1'b0;
      go_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      hold_q     <= hold_d;
      loser_p1_q <= loser_p1_d;
      pp_q       <= pp_d;
      go_q       <= go_d;
    end
  end

  assign ball_x      = bx_q;
  assign ball_y      = by_q;
  assign score_p1    = s1_q;
  assign score_p2    = s2_q;
  assign point_pulse = pp_q;
  assign game_over   = go_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_pong_physics.sv
// Random game play against a frame-level reference model with a snapshot scoreboard.
module tb_pong_physics;
  import pong_pkg::*;

  localparam int CX = 318, CY = 238, BY_MAX = 476, PY0 = 215, PY_MAX = 430;
  localparam int W = 52;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, frame_tick = 1'b0, serve = 1'b0;
  logic        p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
  logic [9:0]  ball_x, ball_y, p1_y, p2_y;
  logic [3:0]  score_p1, score_p2;
  logic        point_pulse, game_over;
  pong_state_e state_dbg;

  pong_physics dut (
    .pixel_clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn), .serve(serve),
    .ball_x(ball_x), .ball_y(ball_y), .p1_y(p1_y), .p2_y(p2_y),
    .score_p1(score_p1), .score_p2(score_p2),
    .point_pulse(point_pulse), .game_over(game_over), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Reference model: whole-frame game rules on plain integers
  int          m_bx, m_by, m_vx, m_vy, m_p1, m_p2, m_s1, m_s2, m_hold;
  bit          m_pp, m_loser_p1;
  pong_state_e m_state;

  logic [W-1:0] exp_q[$];
  int errors = 0, checks = 0;
  bit ev_seen = 1'b0, started = 1'b0;

  function automatic int paddle_move(int y, bit up, bit dn);
    int n = y;
    if (up && !dn) n = y - 4;
    if (dn && !up) n = y + 4;
    if (n < 0) n = 0;
    if (n > PY_MAX) n = PY_MAX;
    return n;
  endfunction

  function automatic bit overlaps(int by, int py);
    return (by + 4 > py) && (by < py + 50);
  endfunction

  function automatic void model_play_frame();
    int nx = m_bx + m_vx;
    int ny = m_by + m_vy;
    bit lost_left = 0, lost_right = 0;
    if (m_vx < 0 && nx <= 5) begin
      if (overlaps(m_by, m_p1)) begin nx = 5; m_vx = 2; end
      else lost_left = 1;
    end else if (m_vx > 0 && nx + 4 >= 635) begin
      if (overlaps(m_by, m_p2)) begin nx = 631; m_vx = -2; end
      else lost_right = 1;
    end
    if (lost_left || lost_right) begin
      if (lost_left && m_s2 < 9) m_s2++;
      if (lost_right && m_s1 < 9) m_s1++;
      m_loser_p1 = lost_left;
      m_pp = 1;
      m_hold = 0;
      m_state = ST_SCORED;
      return;
    end
    if (ny < 0) begin ny = 0; m_vy = -m_vy; end
    else if (ny > BY_MAX) begin ny = BY_MAX; m_vy = -m_vy; end
    m_bx = nx;
    m_by = ny;
  endfunction

  function automatic void model_reset();
    m_state = ST_SERVE; m_bx = CX; m_by = CY; m_vx = 2; m_vy = 2;
    m_p1 = PY0; m_p2 = PY0; m_s1 = 0; m_s2 = 0; m_hold = 0; m_pp = 0; m_loser_p1 = 0;
  endfunction

  function automatic void model_step(bit r, bit t, bit s, bit u1, bit d1, bit u2, bit d2);
    m_pp = 0;
    if (r) begin model_reset(); return; end
    case (m_state)
      ST_SERVE: begin
        if (t) begin m_p1 = paddle_move(m_p1, u1, d1); m_p2 = paddle_move(m_p2, u2, d2); end
        if (s) m_state = ST_PLAY;
      end
      ST_PLAY: if (t) begin
        model_play_frame();
        m_p1 = paddle_move(m_p1, u1, d1);
        m_p2 = paddle_move(m_p2, u2, d2);
      end
      ST_SCORED: if (t) begin
        m_hold++;
        if (m_hold == 60) begin
          m_hold = 0;
          if (m_s1 == 9 || m_s2 == 9) m_state = ST_OVER;
          else begin
            m_state = ST_SERVE; m_bx = CX; m_by = CY;
            m_vx = m_loser_p1 ? -2 : 2;
          end
        end
      end
      ST_OVER: if (s) begin
        m_s1 = 0; m_s2 = 0; m_state = ST_SERVE;
        m_bx = CX; m_by = CY; m_vx = 2; m_vy = 2;
      end
      default: ;
    endcase
  endfunction

  function automatic logic [W-1:0] model_snapshot();
    return {10'(m_bx), 10'(m_by), 10'(m_p1), 10'(m_p2), 4'(m_s1), 4'(m_s2),
            (m_state == ST_OVER), m_pp, m_state};
  endfunction

  // Driver: hold inputs for one clock, then advance the model and log the expectation
  task automatic step(input bit r, input bit t, input bit s);
    rst_n = !r; frame_tick = t; serve = s;
    @(posedge clk);
    #1;
    model_step(r, t, s, p1_up, p1_dn, p2_up, p2_dn);
    if (r || t || s) exp_q.push_back(model_snapshot());
    rst_n = 1'b1; frame_tick = 1'b0; serve = 1'b0;
  endtask

  task automatic frame(input bit serve_on_tick, input bit serve_idle);
    step(1'b0, 1'b1, serve_on_tick);
    step(1'b0, 1'b0, serve_idle);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_buttons(input logic [3:0] b);
    {p1_up, p1_dn, p2_up, p2_dn} = b;
  endtask

  // Monitor: the cycle after any reset/tick/serve, the DUT presents a new snapshot
  always @(posedge clk) begin
    ev_seen <= !rst_n || frame_tick || serve;
    if (!rst_n) started <= 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      if (ev_seen) begin
        logic [W-1:0] exp_v, act_v;
        checks++;
        act_v = {ball_x, ball_y, p1_y, p2_y, score_p1, score_p2, game_over, point_pulse, state_dbg};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL queue_empty t=%0t actual=%h required=an expected entry", $time, act_v);
        end else begin
          exp_v = exp_q.pop_front();
          if (act_v !== exp_v) begin
            errors++;
            $display("FAIL snapshot t=%0t actual bx=%0d by=%0d p1=%0d p2=%0d s=%0d/%0d go=%0b pp=%0b st=%0d required bx=%0d by=%0d p1=%0d p2=%0d s=%0d/%0d go=%0b pp=%0b st=%0d",
              $time, act_v[51:42], act_v[41:32], act_v[31:22], act_v[21:12], act_v[11:8], act_v[7:4],
              act_v[3], act_v[2], act_v[1:0],
              exp_v[51:42], exp_v[41:32], exp_v[31:22], exp_v[21:12], exp_v[11:8], exp_v[7:4],
              exp_v[3], exp_v[2], exp_v[1:0]);
          end
        end
      end else begin
        checks++;
        if (point_pulse !== 1'b0) begin
          errors++;
          $display("FAIL point_pulse_width t=%0t actual=%b required=0", $time, point_pulse);
        end
      end
    end
  end

  initial begin
    model_reset();
    // Reset, then three idle frames: ball stays centered
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) frame(1'b0, 1'b0);

    // Serve between ticks, then p1 holds up for 60 frames, then both buttons
    frame(1'b0, 1'b1);
    set_buttons(4'b1000);
    for (int i = 0; i < 60; i++) frame(1'b0, 1'b0);
    set_buttons(4'b1100);
    for (int i = 0; i < 5; i++) frame(1'b0, 1'b0);

    // Random play until someone wins (bounded)
    for (int f = 0; f < 9000 && m_state != ST_OVER; f++) begin
      bit sv;
      if ($urandom_range(0, 7) == 0) set_buttons(4'($urandom_range(0, 15)));
      sv = 1'b0;
      if (m_state == ST_SERVE && $urandom_range(0, 3) == 0) sv = 1'b1;
      if (m_state == ST_PLAY && $urandom_range(0, 31) == 0) sv = 1'b1;
      frame(1'b0, sv);
    end

    // Game over holds, then serve restarts with cleared scores
    for (int i = 0; i < 4; i++) frame(1'b0, 1'b0);
    frame(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) frame(1'b0, 1'b0);

    // Serve coincident with a tick, play, then reset coincident with a tick mid-play
    step(1'b1, 1'b0, 1'b0);
    frame(1'b1, 1'b0);
    set_buttons(4'b0110);
    for (int i = 0; i < 20; i++) frame(1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) frame(1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
